// File: rtl/resp_capture_pkg.sv
// Shared types and constants for the response-capture MISR block.
package resp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SIG_SEED  = 16'hFFFF;
    localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/resp_capture_misr_step.sv
// Combinational MISR step: shift, feed back MISR_POLY on MSB, fold in the response vector.
module misr_step
    import resp_capture_pkg::*;
#(
    parameter int RESP_W = 13,
    parameter int SIG_W  = 16
) (
    input  logic [SIG_W-1:0]  sig_in,
    input  logic [RESP_W-1:0] resp_in,
    output logic [SIG_W-1:0]  sig_out
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] feedback;

    always_comb begin
        shifted  = {sig_in[SIG_W-2:0], 1'b0};
        feedback = sig_in[SIG_W-1] ? POLY : '0;
        sig_out  = shifted ^ feedback ^ SIG_W'(resp_in);
    end

endmodule

// File: rtl/resp_capture_misr.sv
// Response capture controller: compacts a counted run of response vectors into a MISR signature.
// Optional golden compare output is built when RESP_CAPTURE_GOLDEN_CMP_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, signature/count hold reset values
// RUN     | compacting valid vectors until the latched count is reached
// DONE    | result held; start re-seeds and launches a new run
module resp_capture_misr
    import resp_capture_pkg::*;
#(
    parameter int RESP_W = 13,
    parameter int SIG_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic [RESP_W-1:0] resp_in,
    input  logic              resp_valid,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
`ifdef RESP_CAPTURE_GOLDEN_CMP_EN
    input  logic [SIG_W-1:0]  golden,
    output logic              pass,
`endif
    output logic [CNT_W-1:0]  captured
);

    if (RESP_W > SIG_W) begin : g_width_check
        $error("resp_capture_misr: RESP_W must not exceed SIG_W");
    end

    // Narrower/wider signatures still seed to all-ones.
    localparam logic [SIG_W-1:0] SEED = (SIG_W == 16) ? SIG_W'(SIG_SEED) : {SIG_W{1'b1}};

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] cnt_inc;

    misr_step #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W)
    ) u_misr_step (
        .sig_in  (sig_q),
        .resp_in (resp_in),
        .sig_out (sig_next)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    len_d   = num_cycles;
                    state_d = (num_cycles == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (resp_valid) begin
                    sig_d = sig_next;
                    cnt_d = cnt_inc;
                    // Count never wraps: the run ends on the vector that reaches the latched length.
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign signature = sig_q;
    assign captured  = cnt_q;

`ifdef RESP_CAPTURE_GOLDEN_CMP_EN
    logic pass_q, pass_d;

    // Evaluated on next-state values so pass lines up with done.
    always_comb begin
        pass_d = (state_d == ST_DONE) && (sig_d == golden);
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

endmodule
